ad9226_acq_ctrl: RTL and testbench
==================================

// Module: ad9226_acq_ctrl
// PURPOSE
//  Acquisition sequencer for the AD9226 capture path. Arms on a software start,
//  waits for the ultrasonic fire trigger, then waits a programmable delay.
//  Next it drives ad_data_en/ch_sel into the 12->16 bit formatter for exactly N samples.
//  Finally it holds the frame until the downstream packetiser acknowledges it.
//  Sits between the control register block and ad9226_12bit_to_16bit.
// PARAMETERS
//  LEN_W   16  width of sample-count config/counter
//  DLY_W   16  width of trigger-to-capture delay config/counter
//  FCNT_W  16  width of completed-frame counter
// PORTS
//  clk         in   1       system clock (ADC sample clock domain)
//  reset_n     in   1       asynchronous active-low reset
//  start       in   1       1-cycle pulse: arm a capture (latches cfg_*)
//  abort       in   1       level/pulse: return to IDLE from any state
//  trig        in   1       fire trigger, synchronous to clk; rising edge acts
//  ack         in   1       downstream has consumed the frame
//  cfg_ch_sel  in   2       00 test ramp, 01 ch A, 10 ch B, 11 reserved
//  cfg_delay   in   DLY_W   cycles from trig edge to first sample
//  cfg_length  in   LEN_W   samples per frame (0 = illegal)
//  ad_data_en  out  1       sample enable to formatter
//  ch_sel      out  2       channel select to formatter (latched cfg_ch_sel)
//  frame_sop   out  1       high with first ad_data_en of frame
//  frame_eop   out  1       high with last ad_data_en of frame
//  busy        out  1       state != IDLE
//  done        out  1       frame complete, awaiting ack
//  frame_cnt   out  FCNT_W  acknowledged frames, wraps at 2^FCNT_W
//  err_overrun out  1       sticky: trig edge seen outside ARMED while busy
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, ch_sel 2'b01, latched config 0.
//  All outputs are registered; no combinational input->output paths.
//  States: IDLE, ARMED, DELAY, CAPTURE, WAIT_ACK.
//  IDLE: start with cfg_length!=0 and cfg_ch_sel!=11 -> ARMED. Latch cfg_*.
//    Also clear err_overrun. Otherwise start is ignored and the block stays IDLE.
//  ARMED: trig rise (trig=1, previous sample 0) -> DELAY if delay!=0, else CAPTURE.
//  DELAY: count delay cycles, then CAPTURE.
//  Timing: trig rise sampled at edge k -> ad_data_en high from edge k+1+D
//    for exactly L consecutive cycles (D=delay, L=length).
//  CAPTURE: frame_sop on sample 1; frame_eop on sample L (both if L=1).
//    After sample L -> WAIT_ACK. ad_data_en is low on the next edge.
//  WAIT_ACK: done=1 until ack. On ack: done->0, frame_cnt+1 (wraps), -> IDLE.
//  ack outside WAIT_ACK is ignored. start while busy is ignored; config is unchanged.
//  trig rise in DELAY/CAPTURE/WAIT_ACK: set err_overrun. The capture is not restarted.
//  abort (highest priority, beats start/ack same cycle) -> IDLE next edge.
//    ad_data_en/sop/eop/done drop on that edge. frame_cnt is not incremented.
//  ch_sel is constant from ARMED until the next accepted start.
//  Counters are sized LEN_W/DLY_W. Max frame 2^LEN_W-1 samples, no overflow.
// CONFIGURATION
//  ACQ_AUTO_REARM_EN defined: ack in WAIT_ACK -> ARMED (not IDLE).
//    Latched config is kept, so every fire trigger captures a frame until abort.
//    busy stays 1 while re-armed.
//  Undefined: ack -> IDLE. Each frame needs a new start.
// STRUCTURE
//  Package ad9226_acq_pkg: state enum (3-bit), CH_TEST=2'b00, CH_A=2'b01,
//    CH_B=2'b10, CH_RSVD=2'b11.
//  Sub-module ad9226_trig_edge: registers the previous trig and outputs rise=trig&~prev.
//    Its previous-trig register resets to 0.
//  Everything else stays in one always-block FSM plus its counters.
// TESTING
//  start(ch=01,D=0,L=4), trig rise at edge k -> ad_data_en edges k+1..k+4, sop@k+1, eop@k+4, done@k+5.
//  D=3,L=1 -> single en at k+4 with sop=eop=1. Then ack -> frame_cnt=1, busy=0 next edge.
//  L=0 or ch=11 start -> stays IDLE, busy=0. trig -> no ad_data_en.
//  2nd trig rise during CAPTURE (L=8) -> exactly 8 samples, err_overrun=1 until next start.
//  abort at sample 3 of L=8 -> ad_data_en 0 next edge, no eop/done, frame_cnt unchanged. Repeat with abort in reset mid-CAPTURE -> all outputs 0.
//  ACQ_AUTO_REARM_EN: 3 trigs each followed by ack -> 3 frames, frame_cnt=3. Without it the 2nd trig yields nothing.

Source files
------------

// File: rtl/ad9226_acq_pkg.sv
// Shared types and channel codes for the AD9226 acquisition sequencer.
package ad9226_acq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StDelay,
        StCapture,
        StWaitAck
    } acq_state_e;

    localparam logic [1:0] CH_TEST = 2'b00;
    localparam logic [1:0] CH_A    = 2'b01;
    localparam logic [1:0] CH_B    = 2'b10;
    localparam logic [1:0] CH_RSVD = 2'b11;

endpackage

// File: rtl/ad9226_trig_edge.sv
// Rising-edge detector for the clk-synchronous ultrasonic fire trigger.
module ad9226_trig_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic trig,
    output logic rise
);

    logic trig_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_prev_q <= 1'b0;
        end else begin
            trig_prev_q <= trig;
        end
    end

    assign rise = trig & ~trig_prev_q;

endmodule

// File: rtl/ad9226_acq_ctrl.sv
// Acquisition sequencer: arm, wait trigger, delay, capture N samples, hold for ack.
// Define ACQ_AUTO_REARM_EN to return to ARMED (instead of IDLE) after each ack.
module ad9226_acq_ctrl
    import ad9226_acq_pkg::*;
#(
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned DLY_W  = 16,
    parameter int unsigned FCNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              trig,
    input  logic              ack,
    input  logic [1:0]        cfg_ch_sel,
    input  logic [DLY_W-1:0]  cfg_delay,
    input  logic [LEN_W-1:0]  cfg_length,
    output logic              ad_data_en,
    output logic [1:0]        ch_sel,
    output logic              frame_sop,
    output logic              frame_eop,
    output logic              busy,
    output logic              done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              err_overrun
);

    acq_state_e        state_q, state_d;
    logic [DLY_W-1:0]  dly_q, dly_d, dly_cnt_q, dly_cnt_d;
    logic [LEN_W-1:0]  len_q, len_d, smp_cnt_q, smp_cnt_d;
    logic [1:0]        ch_sel_d;
    logic [FCNT_W-1:0] frame_cnt_d;
    logic              en_d, sop_d, eop_d, done_d, err_d;
    logic              rise;

    ad9226_trig_edge u_trig_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .trig    (trig),
        .rise    (rise)
    );

    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        len_d       = len_q;
        ch_sel_d    = ch_sel;
        dly_cnt_d   = dly_cnt_q;
        smp_cnt_d   = smp_cnt_q;
        frame_cnt_d = frame_cnt;
        err_d       = err_overrun;
        en_d        = 1'b0;
        sop_d       = 1'b0;
        eop_d       = 1'b0;
        done_d      = 1'b0;

        // A second fire while a frame is in flight is flagged, never restarts it.
        if (rise && (state_q inside {StDelay, StCapture, StWaitAck})) begin
            err_d = 1'b1;
        end

        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && (cfg_length != '0) && (cfg_ch_sel != CH_RSVD)) begin
                        state_d  = StArmed;
                        dly_d    = cfg_delay;
                        len_d    = cfg_length;
                        ch_sel_d = cfg_ch_sel;
                        err_d    = 1'b0;
                    end
                end
                StArmed: begin
                    if (rise) begin
                        dly_cnt_d = '0;
                        smp_cnt_d = '0;
                        state_d   = (dly_q != '0) ? StDelay : StCapture;
                    end
                end
                StDelay: begin
                    if (dly_cnt_q == dly_q - DLY_W'(1)) begin
                        state_d = StCapture;
                    end else begin
                        dly_cnt_d = dly_cnt_q + DLY_W'(1);
                    end
                end
                StCapture: begin
                    en_d  = 1'b1;
                    sop_d = (smp_cnt_q == '0);
                    eop_d = (smp_cnt_q == len_q - LEN_W'(1));
                    if (eop_d) begin
                        state_d = StWaitAck;
                    end else begin
                        smp_cnt_d = smp_cnt_q + LEN_W'(1);
                    end
                end
                StWaitAck: begin
                    if (ack) begin
                        frame_cnt_d = frame_cnt + FCNT_W'(1);
`ifdef ACQ_AUTO_REARM_EN
                        state_d     = StArmed;
`else
                        state_d     = StIdle;
`endif
                    end else begin
                        done_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            dly_q       <= '0;
            len_q       <= '0;
            dly_cnt_q   <= '0;
            smp_cnt_q   <= '0;
            ch_sel      <= CH_A;
            frame_cnt   <= '0;
            err_overrun <= 1'b0;
            ad_data_en  <= 1'b0;
            frame_sop   <= 1'b0;
            frame_eop   <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            len_q       <= len_d;
            dly_cnt_q   <= dly_cnt_d;
            smp_cnt_q   <= smp_cnt_d;
            ch_sel      <= ch_sel_d;
            frame_cnt   <= frame_cnt_d;
            err_overrun <= err_d;
            ad_data_en  <= en_d;
            frame_sop   <= sop_d;
            frame_eop   <= eop_d;
            done        <= done_d;
            busy        <= (state_d != StIdle);
        end
    end

endmodule

// File: tb/tb_ad9226_acq_ctrl.sv
// Directed, table-driven bench for ad9226_acq_ctrl (default and ACQ_AUTO_REARM_EN builds).
module tb_ad9226_acq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, trig = 1'b0, ack = 1'b0;
    logic [1:0]  cfg_ch_sel = 2'b01;
    logic [15:0] cfg_delay = '0, cfg_length = '0;
    logic        ad_data_en, frame_sop, frame_eop, busy, done, err_overrun;
    logic [1:0]  ch_sel;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        en, sop, eop, busy, done;
        logic [15:0] fcnt;
        logic [1:0]  ch;
        logic        err;
    } out_t;

    typedef struct packed {
        logic        s, a, t, k;
        logic [1:0]  ch;
        logic [15:0] d, l;
        out_t        exp;
    } vec_t;

    vec_t vecs[$];

    ad9226_acq_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .trig        (trig),
        .ack         (ack),
        .cfg_ch_sel  (cfg_ch_sel),
        .cfg_delay   (cfg_delay),
        .cfg_length  (cfg_length),
        .ad_data_en  (ad_data_en),
        .ch_sel      (ch_sel),
        .frame_sop   (frame_sop),
        .frame_eop   (frame_eop),
        .busy        (busy),
        .done        (done),
        .frame_cnt   (frame_cnt),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    function automatic out_t o(bit en, bit sop, bit eop, bit bsy, bit dn, int fc, bit [1:0] c,
                               bit er);
        o = {en, sop, eop, bsy, dn, 16'(fc), c, er};
    endfunction

    function automatic vec_t v(bit s, bit a, bit t, bit k, bit [1:0] c, int d, int l, out_t e);
        v = {s, a, t, k, c, 16'(d), 16'(l), e};
    endfunction

    function automatic out_t cur();
        cur = {ad_data_en, frame_sop, frame_eop, busy, done, frame_cnt, ch_sel, err_overrun};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input out_t exp);
        out_t a;
        a = cur();
        checks++;
        if (a !== exp) begin
            errors++;
            $display("FAIL %s: got en%b sop%b eop%b busy%b done%b fcnt%0d ch%b err%b, expected en%b sop%b eop%b busy%b done%b fcnt%0d ch%b err%b",
                     name, a.en, a.sop, a.eop, a.busy, a.done, a.fcnt, a.ch, a.err,
                     exp.en, exp.sop, exp.eop, exp.busy, exp.done, exp.fcnt, exp.ch, exp.err);
        end
    endtask

    task automatic do_start(input logic [1:0] c, input int d, input int l);
        start = 1'b1; cfg_ch_sel = c; cfg_delay = 16'(d); cfg_length = 16'(l);
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n_en, n_sop, n_eop, n_done;
        bit got;

        repeat (2) @(posedge clk);
        #1;
        chk_out("reset_state", o(0, 0, 0, 0, 0, 0, 2'b01, 0));
        reset_n = 1'b1;
        tick();
        chk_out("post_reset_idle", o(0, 0, 0, 0, 0, 0, 2'b01, 0));

`ifndef ACQ_AUTO_REARM_EN
        // D=0 L=4, trig rise at vector 2
        vecs.push_back(v(1, 0, 0, 0, 2'b01, 0, 4, o(0, 0, 0, 1, 0, 0, 2'b01, 0)));
        vecs.push_back(v(0, 0, 0, 0, 2'b01, 0, 4, o(0, 0, 0, 1, 0, 0, 2'b01, 0)));
        vecs.push_back(v(0, 0, 1, 0, 2'b01, 0, 4, o(0, 0, 0, 1, 0, 0, 2'b01, 0)));
        vecs.push_back(v(0, 0, 1, 0, 2'b01, 0, 4, o(1, 1, 0, 1, 0, 0, 2'b01, 0)));
        vecs.push_back(v(0, 0, 0, 0, 2'b01, 0, 4, o(1, 0, 0, 1, 0, 0, 2'b01, 0)));
        vecs.push_back(v(0, 0, 0, 0, 2'b01, 0, 4, o(1, 0, 0, 1, 0, 0, 2'b01, 0)));
        vecs.push_back(v(0, 0, 0, 0, 2'b01, 0, 4, o(1, 0, 1, 1, 0, 0, 2'b01, 0)));
        vecs.push_back(v(0, 0, 0, 0, 2'b01, 0, 4, o(0, 0, 0, 1, 1, 0, 2'b01, 0)));
        vecs.push_back(v(0, 0, 0, 0, 2'b01, 0, 4, o(0, 0, 0, 1, 1, 0, 2'b01, 0)));
        vecs.push_back(v(0, 0, 0, 1, 2'b01, 0, 4, o(0, 0, 0, 0, 0, 1, 2'b01, 0)));
        vecs.push_back(v(0, 0, 0, 0, 2'b01, 0, 4, o(0, 0, 0, 0, 0, 1, 2'b01, 0)));
        // D=3 L=1 on channel B
        vecs.push_back(v(1, 0, 0, 0, 2'b10, 3, 1, o(0, 0, 0, 1, 0, 1, 2'b10, 0)));
        vecs.push_back(v(0, 0, 1, 0, 2'b10, 3, 1, o(0, 0, 0, 1, 0, 1, 2'b10, 0)));
        vecs.push_back(v(0, 0, 0, 0, 2'b10, 3, 1, o(0, 0, 0, 1, 0, 1, 2'b10, 0)));
        vecs.push_back(v(0, 0, 0, 0, 2'b10, 3, 1, o(0, 0, 0, 1, 0, 1, 2'b10, 0)));
        vecs.push_back(v(0, 0, 0, 0, 2'b10, 3, 1, o(0, 0, 0, 1, 0, 1, 2'b10, 0)));
        vecs.push_back(v(0, 0, 0, 0, 2'b10, 3, 1, o(1, 1, 1, 1, 0, 1, 2'b10, 0)));
        vecs.push_back(v(0, 0, 0, 0, 2'b10, 3, 1, o(0, 0, 0, 1, 1, 1, 2'b10, 0)));
        vecs.push_back(v(0, 0, 0, 1, 2'b10, 3, 1, o(0, 0, 0, 0, 0, 2, 2'b10, 0)));
        // Illegal starts, trig and ack while idle
        vecs.push_back(v(1, 0, 0, 0, 2'b01, 0, 0, o(0, 0, 0, 0, 0, 2, 2'b10, 0)));
        vecs.push_back(v(1, 0, 0, 0, 2'b11, 0, 4, o(0, 0, 0, 0, 0, 2, 2'b10, 0)));
        vecs.push_back(v(0, 0, 1, 0, 2'b01, 0, 4, o(0, 0, 0, 0, 0, 2, 2'b10, 0)));
        vecs.push_back(v(0, 0, 0, 0, 2'b01, 0, 4, o(0, 0, 0, 0, 0, 2, 2'b10, 0)));
        vecs.push_back(v(0, 0, 0, 1, 2'b01, 0, 4, o(0, 0, 0, 0, 0, 2, 2'b10, 0)));
        // Start while armed is ignored: L stays 2, ch stays 01
        vecs.push_back(v(1, 0, 0, 0, 2'b01, 0, 2, o(0, 0, 0, 1, 0, 2, 2'b01, 0)));
        vecs.push_back(v(1, 0, 0, 0, 2'b10, 5, 9, o(0, 0, 0, 1, 0, 2, 2'b01, 0)));
        vecs.push_back(v(0, 0, 1, 0, 2'b10, 5, 9, o(0, 0, 0, 1, 0, 2, 2'b01, 0)));
        vecs.push_back(v(0, 0, 0, 0, 2'b10, 5, 9, o(1, 1, 0, 1, 0, 2, 2'b01, 0)));
        vecs.push_back(v(0, 0, 0, 0, 2'b10, 5, 9, o(1, 0, 1, 1, 0, 2, 2'b01, 0)));
        vecs.push_back(v(0, 0, 0, 0, 2'b10, 5, 9, o(0, 0, 0, 1, 1, 2, 2'b01, 0)));
        vecs.push_back(v(0, 0, 0, 1, 2'b10, 5, 9, o(0, 0, 0, 0, 0, 3, 2'b01, 0)));
        // No re-arm: a further trig does nothing
        vecs.push_back(v(0, 0, 1, 0, 2'b10, 5, 9, o(0, 0, 0, 0, 0, 3, 2'b01, 0)));
        vecs.push_back(v(0, 0, 0, 0, 2'b10, 5, 9, o(0, 0, 0, 0, 0, 3, 2'b01, 0)));

        foreach (vecs[i]) begin
            start = vecs[i].s; abort = vecs[i].a; trig = vecs[i].t; ack = vecs[i].k;
            cfg_ch_sel = vecs[i].ch; cfg_delay = vecs[i].d; cfg_length = vecs[i].l;
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].exp);
        end
        start = 0; abort = 0; trig = 0; ack = 0;

        // Second trig rise mid-capture: frame length unchanged, overrun flagged
        do_start(2'b01, 0, 8);
        trig = 1'b1;
        tick();
        n_en = 0; n_sop = 0; n_eop = 0;
        for (int i = 0; i < 16; i++) begin
            trig = (i == 3);
            tick();
            n_en += int'(ad_data_en); n_sop += int'(frame_sop); n_eop += int'(frame_eop);
        end
        trig = 1'b0;
        chk("ovr_samples", n_en, 8);
        chk("ovr_sop", n_sop, 1);
        chk("ovr_eop", n_eop, 1);
        chk("ovr_err", err_overrun, 1);
        chk("ovr_done", done, 1);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("ovr_fcnt", frame_cnt, 4);
        chk("ovr_err_sticky", err_overrun, 1);
        do_start(2'b10, 0, 8);
        chk("ovr_err_clear", err_overrun, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_armed_busy", busy, 0);

        // Abort at sample 3 of 8
        do_start(2'b01, 0, 8);
        trig = 1'b1; tick(); trig = 1'b0;
        tick(); tick(); tick();
        chk("abort_pre_en", ad_data_en, 1);
        abort = 1'b1; ack = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; ack = 1'b0; start = 1'b0;
        chk_out("abort_edge", o(0, 0, 0, 0, 0, 4, 2'b01, 0));
        n_en = 0; n_eop = 0; n_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_en += int'(ad_data_en); n_eop += int'(frame_eop); n_done += int'(done);
        end
        chk("abort_no_activity", n_en + n_eop + n_done, 0);
        chk("abort_fcnt", frame_cnt, 4);

        // Reset asserted mid-capture
        do_start(2'b10, 0, 8);
        trig = 1'b1; tick(); trig = 1'b0;
        tick(); tick();
        chk("rst_pre_en", ad_data_en, 1);
        #2 reset_n = 1'b0;
        #1 chk_out("rst_mid_capture", o(0, 0, 0, 0, 0, 0, 2'b01, 0));
        tick();
        reset_n = 1'b1;
        tick(); tick();
        chk_out("rst_after_release", o(0, 0, 0, 0, 0, 0, 2'b01, 0));
`else
        // Auto re-arm: three trigs, each acked, yield three frames
        do_start(2'b01, 0, 2);
        for (int f = 0; f < 3; f++) begin
            trig = 1'b1; tick(); trig = 1'b0;
            got = 1'b0;
            n_en = 0;
            for (int i = 0; i < 20 && !got; i++) begin
                tick();
                n_en += int'(ad_data_en);
                got = done;
            end
            chk($sformatf("rearm_done%0d", f), got, 1);
            chk($sformatf("rearm_len%0d", f), n_en, 2);
            ack = 1'b1; tick(); ack = 1'b0;
            chk($sformatf("rearm_busy%0d", f), busy, 1);
            chk($sformatf("rearm_fcnt%0d", f), frame_cnt, f + 1);
        end
        abort = 1'b1; tick(); abort = 1'b0;
        chk_out("rearm_abort", o(0, 0, 0, 0, 0, 3, 2'b01, 0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
